// File: rtl/alu_exec_if.sv
// RS-to-execute issue bus and execute CDB broadcast, grouped for the ALU execute stage.
// The master drives the issued op (RS side); the slave is the execute unit.
interface alu_exec_if #(
  parameter int DATA_W  = 32,
  parameter int ROBID_W = 32
);
  logic               ALU_flag;
  logic [DATA_W-1:0]  ALU_V1;
  logic [DATA_W-1:0]  ALU_V2;
  logic [DATA_W-1:0]  ALU_A;
  logic [DATA_W-1:0]  ALU_inst_pc;
  logic [5:0]         ALU_inst_code;
  logic [ROBID_W-1:0] ALU_inst_rob_id;

  logic               ex_cdb_flag;
  logic [ROBID_W-1:0] ex_cdb_rob_id;
  logic [DATA_W-1:0]  ex_cdb_val;
  logic               ex_brc_flag;
  logic               ex_brc_taken;
  logic [DATA_W-1:0]  ex_brc_target;

  modport master (
    output ALU_flag, ALU_V1, ALU_V2, ALU_A, ALU_inst_pc, ALU_inst_code, ALU_inst_rob_id,
    input  ex_cdb_flag, ex_cdb_rob_id, ex_cdb_val, ex_brc_flag, ex_brc_taken, ex_brc_target
  );

  modport slave (
    input  ALU_flag, ALU_V1, ALU_V2, ALU_A, ALU_inst_pc, ALU_inst_code, ALU_inst_rob_id,
    output ex_cdb_flag, ex_cdb_rob_id, ex_cdb_val, ex_brc_flag, ex_brc_taken, ex_brc_target
  );
endinterface

// File: rtl/alu_exec.sv
// Single-cycle RV32I integer/branch/jump execute stage; result broadcast on the
// execute CDB one cycle after issue, with resolved next PC for control flow.
module alu_exec #(
  parameter int DATA_W  = 32,
  parameter int ROBID_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       jump_wrong_stall,
  alu_exec_if.slave  bus
);

  localparam logic [5:0] OP_LUI   = 6'd1;
  localparam logic [5:0] OP_AUIPC = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_JALR  = 6'd4;
  localparam logic [5:0] OP_BEQ   = 6'd5;
  localparam logic [5:0] OP_BNE   = 6'd6;
  localparam logic [5:0] OP_BLT   = 6'd7;
  localparam logic [5:0] OP_BGE   = 6'd8;
  localparam logic [5:0] OP_BLTU  = 6'd9;
  localparam logic [5:0] OP_BGEU  = 6'd10;
  localparam logic [5:0] OP_ADDI  = 6'd19;
  localparam logic [5:0] OP_SLTI  = 6'd20;
  localparam logic [5:0] OP_SLTIU = 6'd21;
  localparam logic [5:0] OP_XORI  = 6'd22;
  localparam logic [5:0] OP_ORI   = 6'd23;
  localparam logic [5:0] OP_ANDI  = 6'd24;
  localparam logic [5:0] OP_SLLI  = 6'd25;
  localparam logic [5:0] OP_SRLI  = 6'd26;
  localparam logic [5:0] OP_SRAI  = 6'd27;
  localparam logic [5:0] OP_ADD   = 6'd28;
  localparam logic [5:0] OP_SUB   = 6'd29;
  localparam logic [5:0] OP_SLL   = 6'd30;
  localparam logic [5:0] OP_SLT   = 6'd31;
  localparam logic [5:0] OP_SLTU  = 6'd32;
  localparam logic [5:0] OP_XOR   = 6'd33;
  localparam logic [5:0] OP_SRL   = 6'd34;
  localparam logic [5:0] OP_SRA   = 6'd35;
  localparam logic [5:0] OP_OR    = 6'd36;
  localparam logic [5:0] OP_AND   = 6'd37;

  function automatic logic [DATA_W-1:0] bool_word(input logic b);
    return {{(DATA_W-1){1'b0}}, b};
  endfunction

  logic signed [DATA_W-1:0] v1_s;
  logic signed [DATA_W-1:0] v2_s;
  logic signed [DATA_W-1:0] a_s;
  logic        [DATA_W-1:0] v1;
  logic        [DATA_W-1:0] v2;
  logic        [DATA_W-1:0] a;
  logic        [DATA_W-1:0] pc4;
  logic        [DATA_W-1:0] pc_a;
  logic        [DATA_W-1:0] jalr_sum;

  logic              [DATA_W-1:0] val_c;
  logic                           brc_c;
  logic                           taken_c;
  logic              [DATA_W-1:0] tgt_c;

  assign v1       = bus.ALU_V1;
  assign v2       = bus.ALU_V2;
  assign a        = bus.ALU_A;
  assign v1_s     = bus.ALU_V1;
  assign v2_s     = bus.ALU_V2;
  assign a_s      = bus.ALU_A;
  assign pc4      = bus.ALU_inst_pc + DATA_W'(4);
  assign pc_a     = bus.ALU_inst_pc + bus.ALU_A;
  assign jalr_sum = bus.ALU_V1 + bus.ALU_A;

  always_comb begin
    val_c   = '0;
    brc_c   = 1'b0;
    taken_c = 1'b0;
    case (bus.ALU_inst_code)
      OP_LUI:   val_c = a;
      OP_AUIPC: val_c = pc_a;
      OP_JAL:   begin val_c = pc4; brc_c = 1'b1; taken_c = 1'b1; end
      OP_JALR:  begin val_c = pc4; brc_c = 1'b1; taken_c = 1'b1; end
      OP_BEQ:   begin brc_c = 1'b1; taken_c = (v1 == v2);   end
      OP_BNE:   begin brc_c = 1'b1; taken_c = (v1 != v2);   end
      OP_BLT:   begin brc_c = 1'b1; taken_c = (v1_s <  v2_s); end
      OP_BGE:   begin brc_c = 1'b1; taken_c = (v1_s >= v2_s); end
      OP_BLTU:  begin brc_c = 1'b1; taken_c = (v1 <  v2);   end
      OP_BGEU:  begin brc_c = 1'b1; taken_c = (v1 >= v2);   end
      OP_ADDI:  val_c = v1 + a;
      OP_SLTI:  val_c = bool_word(v1_s < a_s);
      OP_SLTIU: val_c = bool_word(v1 < a);
      OP_XORI:  val_c = v1 ^ a;
      OP_ORI:   val_c = v1 | a;
      OP_ANDI:  val_c = v1 & a;
      OP_SLLI:  val_c = v1 << a[4:0];
      OP_SRLI:  val_c = v1 >> a[4:0];
      OP_SRAI:  val_c = v1_s >>> a[4:0];
      OP_ADD:   val_c = v1 + v2;
      OP_SUB:   val_c = v1 - v2;
      OP_SLL:   val_c = v1 << v2[4:0];
      OP_SLT:   val_c = bool_word(v1_s < v2_s);
      OP_SLTU:  val_c = bool_word(v1 < v2);
      OP_XOR:   val_c = v1 ^ v2;
      OP_SRL:   val_c = v1 >> v2[4:0];
      OP_SRA:   val_c = v1_s >>> v2[4:0];
      OP_OR:    val_c = v1 | v2;
      OP_AND:   val_c = v1 & v2;
      default:  val_c = '0;
    endcase
  end

  // JALR clears bit 0 of the computed target; every non-taken path falls through to pc+4.
  always_comb begin
    tgt_c = pc4;
    if (bus.ALU_inst_code == OP_JALR)
      tgt_c = {jalr_sum[DATA_W-1:1], 1'b0};
    else if (taken_c)
      tgt_c = pc_a;
  end

  // ---- stage p1: CDB broadcast registers ----
  logic               vld_p1;
  logic               brc_p1;
  logic               taken_p1;
  logic [ROBID_W-1:0] rob_p1;
  logic [DATA_W-1:0]  val_p1;
  logic [DATA_W-1:0]  tgt_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1   <= 1'b0;
      brc_p1   <= 1'b0;
      taken_p1 <= 1'b0;
      rob_p1   <= '0;
      val_p1   <= '0;
      tgt_p1   <= '0;
    end else if (jump_wrong_stall) begin
      vld_p1 <= 1'b0;
      brc_p1 <= 1'b0;
    end else if (rdy) begin
      vld_p1   <= bus.ALU_flag;
      brc_p1   <= bus.ALU_flag & brc_c;
      taken_p1 <= bus.ALU_flag & taken_c;
      if (bus.ALU_flag) begin
        rob_p1 <= bus.ALU_inst_rob_id;
        val_p1 <= val_c;
        tgt_p1 <= tgt_c;
      end
    end
  end

  assign bus.ex_cdb_flag   = vld_p1;
  assign bus.ex_cdb_rob_id = rob_p1;
  assign bus.ex_cdb_val    = val_p1;
  assign bus.ex_brc_flag   = brc_p1;
  assign bus.ex_brc_taken  = taken_p1;
  assign bus.ex_brc_target = tgt_p1;

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed literal cases plus randomized ops compared every
// cycle against a behavioural RV32I execute model.
module tb_alu_exec;

  localparam bit [5:0] LUI = 6'd1, AUIPC = 6'd2, JAL = 6'd3, JALR = 6'd4;
  localparam bit [5:0] BEQ = 6'd5, BNE = 6'd6, BLT = 6'd7, BGE = 6'd8, BLTU = 6'd9, BGEU = 6'd10;
  localparam bit [5:0] ADDI = 6'd19, SLTI = 6'd20, SLTIU = 6'd21, XORI = 6'd22, ORI = 6'd23;
  localparam bit [5:0] ANDI = 6'd24, SLLI = 6'd25, SRLI = 6'd26, SRAI = 6'd27;
  localparam bit [5:0] ADD = 6'd28, SUB = 6'd29, SLL = 6'd30, SLT = 6'd31, SLTU = 6'd32;
  localparam bit [5:0] XOR = 6'd33, SRL = 6'd34, SRA = 6'd35, OR = 6'd36, AND = 6'd37;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  logic jws = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   cmp_en = 1'b0;

  alu_exec_if #(.DATA_W(32), .ROBID_W(32)) bus ();

  alu_exec #(.DATA_W(32), .ROBID_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong_stall(jws), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference semantics straight from the instruction definitions.
  function automatic void ref_op(input bit [5:0] code, input bit [31:0] v1, v2, a, pc,
                                 output bit [31:0] val, output bit brc, output bit taken,
                                 output bit [31:0] tgt);
    int signed s1 = v1, s2 = v2, sa = a;
    val = 0; brc = 0; taken = 0;
    case (code)
      LUI:   val = a;
      AUIPC: val = pc + a;
      JAL:   begin val = pc + 4; brc = 1; taken = 1; end
      JALR:  begin val = pc + 4; brc = 1; taken = 1; end
      BEQ:   begin brc = 1; taken = (v1 == v2); end
      BNE:   begin brc = 1; taken = (v1 != v2); end
      BLT:   begin brc = 1; taken = (s1 < s2); end
      BGE:   begin brc = 1; taken = (s1 >= s2); end
      BLTU:  begin brc = 1; taken = (v1 < v2); end
      BGEU:  begin brc = 1; taken = (v1 >= v2); end
      ADDI:  val = v1 + a;
      SLTI:  val = (s1 < sa) ? 1 : 0;
      SLTIU: val = (v1 < a) ? 1 : 0;
      XORI:  val = v1 ^ a;
      ORI:   val = v1 | a;
      ANDI:  val = v1 & a;
      SLLI:  val = v1 << (a % 32);
      SRLI:  val = v1 >> (a % 32);
      SRAI:  val = s1 >>> (a % 32);
      ADD:   val = v1 + v2;
      SUB:   val = v1 - v2;
      SLL:   val = v1 << (v2 % 32);
      SLT:   val = (s1 < s2) ? 1 : 0;
      SLTU:  val = (v1 < v2) ? 1 : 0;
      XOR:   val = v1 ^ v2;
      SRL:   val = v1 >> (v2 % 32);
      SRA:   val = s1 >>> (v2 % 32);
      OR:    val = v1 | v2;
      AND:   val = v1 & v2;
      default: val = 0;
    endcase
    if (code == JALR)   tgt = (v1 + a) & 32'hFFFF_FFFE;
    else if (taken)     tgt = pc + a;
    else                tgt = pc + 4;
  endfunction

  bit        m_flag = 0, m_brc = 0, m_taken = 0;
  bit [31:0] m_val = 0, m_tgt = 0, m_rob = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_flag = 0; m_brc = 0; m_taken = 0; m_val = 0; m_tgt = 0; m_rob = 0;
    end else if (jws) begin
      m_flag = 0; m_brc = 0;
    end else if (rdy) begin
      m_flag = bus.ALU_flag;
      m_brc  = 0;
      if (bus.ALU_flag) begin
        ref_op(bus.ALU_inst_code, bus.ALU_V1, bus.ALU_V2, bus.ALU_A, bus.ALU_inst_pc,
               m_val, m_brc, m_taken, m_tgt);
        m_rob = bus.ALU_inst_rob_id;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_cdb_flag", {31'd0, bus.ex_cdb_flag}, {31'd0, m_flag});
      chk("cmp_brc_flag", {31'd0, bus.ex_brc_flag}, {31'd0, m_brc});
      if (m_flag) begin
        chk("cmp_rob", bus.ex_cdb_rob_id, m_rob);
        chk("cmp_val", bus.ex_cdb_val, m_val);
        chk("cmp_taken", {31'd0, bus.ex_brc_taken}, {31'd0, m_taken});
        chk("cmp_target", bus.ex_brc_target, m_tgt);
      end
    end
  end

  task automatic step(input bit f, input bit [5:0] code, input bit [31:0] v1, v2, a, pc, rob);
    bus.ALU_flag = f; bus.ALU_inst_code = code; bus.ALU_V1 = v1; bus.ALU_V2 = v2;
    bus.ALU_A = a; bus.ALU_inst_pc = pc; bus.ALU_inst_rob_id = rob;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 6'd0, 0, 0, 0, 0, 0);
  endtask

  bit [31:0] r_val, r_tgt;
  bit        r_brc, r_taken;

  initial begin
    bus.ALU_flag = 0; bus.ALU_inst_code = 0; bus.ALU_V1 = 0; bus.ALU_V2 = 0;
    bus.ALU_A = 0; bus.ALU_inst_pc = 0; bus.ALU_inst_rob_id = 0;
    repeat (2) @(negedge clk);
    chk("rst_cdb_flag", {31'd0, bus.ex_cdb_flag}, 0);
    chk("rst_brc_flag", {31'd0, bus.ex_brc_flag}, 0);
    chk("rst_taken", {31'd0, bus.ex_brc_taken}, 0);
    chk("rst_val", bus.ex_cdb_val, 0);
    chk("rst_rob", bus.ex_cdb_rob_id, 0);
    chk("rst_target", bus.ex_brc_target, 0);
    rst = 1; cmp_en = 1;

    ref_op(BLT, 32'hFFFF_FFFF, 0, 32'hFFFF_FFF8, 100, r_val, r_brc, r_taken, r_tgt);
    chk("model_blt_target", r_tgt, 92);
    ref_op(SRAI, 32'h8000_0000, 0, 32'h24, 0, r_val, r_brc, r_taken, r_tgt);
    chk("model_srai", r_val, 32'hF800_0000);

    step(1, ADD, 32'h7FFF_FFFF, 1, 0, 0, 5);
    chk("t1_flag", {31'd0, bus.ex_cdb_flag}, 1);
    chk("t1_rob", bus.ex_cdb_rob_id, 5);
    chk("t1_val", bus.ex_cdb_val, 32'h8000_0000);
    idle();
    chk("t1_flag_fall", {31'd0, bus.ex_cdb_flag}, 0);

    step(1, SRAI, 32'h8000_0000, 0, 32'h24, 0, 6);
    chk("t2_srai", bus.ex_cdb_val, 32'hF800_0000);
    step(1, SLTU, 1, 32'hFFFF_FFFF, 0, 0, 7);
    chk("t2_sltu", bus.ex_cdb_val, 1);
    step(1, SLT, 1, 32'hFFFF_FFFF, 0, 0, 8);
    chk("t2_slt", bus.ex_cdb_val, 0);

    step(1, BLT, 32'hFFFF_FFFF, 0, 32'hFFFF_FFF8, 100, 9);
    chk("t3_blt_brc", {31'd0, bus.ex_brc_flag}, 1);
    chk("t3_blt_taken", {31'd0, bus.ex_brc_taken}, 1);
    chk("t3_blt_target", bus.ex_brc_target, 92);
    chk("t3_blt_val", bus.ex_cdb_val, 0);
    step(1, BLTU, 32'hFFFF_FFFF, 0, 32'hFFFF_FFF8, 100, 10);
    chk("t3_bltu_taken", {31'd0, bus.ex_brc_taken}, 0);
    chk("t3_bltu_target", bus.ex_brc_target, 104);

    step(1, JALR, 203, 0, 4, 64, 11);
    chk("t4_jalr_val", bus.ex_cdb_val, 68);
    chk("t4_jalr_taken", {31'd0, bus.ex_brc_taken}, 1);
    chk("t4_jalr_target", bus.ex_brc_target, 206);

    step(1, ADD, 1, 2, 0, 0, 1);
    chk("t5_first", {31'd0, bus.ex_cdb_flag}, 1);
    chk("t5_first_rob", bus.ex_cdb_rob_id, 1);
    jws = 1;
    step(1, ADD, 3, 4, 0, 0, 2);
    chk("t5_dropped", {31'd0, bus.ex_cdb_flag}, 0);
    jws = 0;
    step(1, ADD, 5, 6, 0, 0, 3);
    chk("t5_third", {31'd0, bus.ex_cdb_flag}, 1);
    chk("t5_third_rob", bus.ex_cdb_rob_id, 3);
    chk("t5_third_val", bus.ex_cdb_val, 11);

    step(1, ADD, 2, 3, 0, 0, 9);
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("t6_frozen_flag", {31'd0, bus.ex_cdb_flag}, 1);
      chk("t6_frozen_rob", bus.ex_cdb_rob_id, 9);
      chk("t6_frozen_val", bus.ex_cdb_val, 5);
    end
    rdy = 1;
    idle();
    chk("t6_release", {31'd0, bus.ex_cdb_flag}, 0);

    for (int i = 0; i < 2000; i++) begin
      bit [31:0] v1, v2;
      jws = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 7) != 0);
      v2  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom;
      v1  = ($urandom_range(0, 3) == 0) ? v2 : $urandom;
      step($urandom_range(0, 3) != 0, 6'($urandom_range(0, 40)), v1, v2,
           $urandom, $urandom & 32'hFFFF_FFFC, $urandom);
    end
    jws = 0; rdy = 1;

    step(1, ADD, 7, 8, 0, 0, 12);
    chk("t6_pre_rst_flag", {31'd0, bus.ex_cdb_flag}, 1);
    #2 rst = 0;
    #1;
    chk("t6_async_rst_flag", {31'd0, bus.ex_cdb_flag}, 0);
    chk("t6_async_rst_val", bus.ex_cdb_val, 0);
    @(negedge clk);
    rst = 1;
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
